neuron_accumulator: RTL

//  Sequential multiply-accumulate neuron front end: consumes one (activation, weight) pair per

---
 rtl/neuron_accumulator.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/neuron_accumulator.sv
// Sequential multiply-accumulate neuron front end.
// Accepts one (activation, weight) pair per input handshake, accumulates
// N_INPUTS full-precision products plus a bias, then holds the saturated
// Q(WIDTH-FRAC).FRAC weighted sum until the downstream stage consumes it.
//
// state | meaning
// ------+-----------------------------------------------------------------
// ACCUM | accepting pairs; in_ready=1, out_valid=0
// DONE  | result presented on out_sum/out_sat; in_ready=0, out_valid=1
module neuron_accumulator #(
    parameter int N_INPUTS = 8,
    parameter int WIDTH    = 32,
    parameter int FRAC     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_weight,
    input  logic [WIDTH-1:0] bias,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_sat
);

    // Headroom of clog2(N)+2 bits above the product width means the sum of
    // N products plus a shifted bias can never wrap.
    localparam int ACC_W = 2*WIDTH + $clog2(N_INPUTS) + 2;
    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

    localparam logic signed [ACC_W-1:0] SUM_MAX =
        {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SUM_MIN =
        {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t                    state;
    logic [CNT_W-1:0]          count;
    logic signed [ACC_W-1:0]   acc;

    logic signed [2*WIDTH-1:0] data_ext;
    logic signed [2*WIDTH-1:0] weight_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   acc_base;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W-1:0]   sum_full;
    logic [WIDTH-1:0]          sum_next;
    logic                      sat_next;
    logic                      in_fire;
    logic                      last_beat;

    // Full-precision signed product; operands are sign-extended so the low
    // 2*WIDTH bits of the multiply are the exact two's-complement product.
    assign data_ext   = {{WIDTH{in_data[WIDTH-1]}}, in_data};
    assign weight_ext = {{WIDTH{in_weight[WIDTH-1]}}, in_weight};
    assign prod       = data_ext * weight_ext;
    assign prod_ext   = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};

    // Bias is aligned to the product's binary point (2*FRAC fractional bits).
    assign bias_ext   = {{(ACC_W-WIDTH){bias[WIDTH-1]}}, bias} <<< FRAC;

    // The first beat of a vector seeds from the bias, ignoring any stale acc.
    assign acc_base   = (count == '0) ? bias_ext : acc;
    assign acc_next   = acc_base + prod_ext;
    assign sum_full   = acc_next >>> FRAC;

    assign in_fire    = in_valid & in_ready;
    assign last_beat  = (count == LAST_BEAT);

    // Clamp the rescaled sum into the signed output range.
    always_comb begin
        sum_next = sum_full[WIDTH-1:0];
        sat_next = 1'b0;
        if (sum_full > SUM_MAX) begin
            sum_next = {1'b0, {(WIDTH-1){1'b1}}};
            sat_next = 1'b1;
        end else if (sum_full < SUM_MIN) begin
            sum_next = {1'b1, {(WIDTH-1){1'b0}}};
            sat_next = 1'b1;
        end
    end

    // Vector sequencing, accumulation and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            count     <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_fire) begin
                        acc <= acc_next;
                        if (last_beat) begin
                            count     <= '0;
                            out_sum   <= sum_next;
                            out_sat   <= sat_next;
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // No bypass: a new pair is only taken the cycle after
                    // the result handshake.
                    if (out_ready) begin
                        acc       <= '0;
                        state     <= ACCUM;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    count     <= '0;
                    acc       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
